// File: rtl/pc_unit_if.sv
// pc_unit_if: groups the PC-select inputs and the PC/return-stack status
// outputs of pc_unit. The slave modport is the pc_unit side, the master
// modport is the controller (or bench) side.
interface pc_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] BUS;
  logic [WIDTH-1:0] ADDR;
  logic [WIDTH-1:0] VEC_IN;
  logic [2:0]       PCMUX;
  logic             LD_PC;
  logic             CLR_ERR;
  logic [WIDTH-1:0] PC_OUT;
  logic [WIDTH-1:0] PC_INC;
  logic [CW-1:0]    STK_COUNT;
  logic             STK_FULL;
  logic             STK_EMPTY;
  logic             STK_ERR;
  logic             ALIGN_FAULT;

  modport slave (
    input  BUS, ADDR, VEC_IN, PCMUX, LD_PC, CLR_ERR,
    output PC_OUT, PC_INC, STK_COUNT, STK_FULL, STK_EMPTY, STK_ERR, ALIGN_FAULT
  );

  modport master (
    output BUS, ADDR, VEC_IN, PCMUX, LD_PC, CLR_ERR,
    input  PC_OUT, PC_INC, STK_COUNT, STK_FULL, STK_EMPTY, STK_ERR, ALIGN_FAULT
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: registered LC-3b program counter with next-PC select
// (INC/BUS/ADDR/VEC/RET) and a hardware return stack of DEPTH entries.
// VEC pushes the link PC (PC+INC_STEP), RET pops it back into the PC.
// STK_ERR is a sticky flag for stack overflow, underflow and reserved selects.
// Optional feature macro: PC_ALIGN_CHK_EN -- when defined, odd targets of
// BUS/ADDR/VEC/RET loads are rejected and ALIGN_FAULT pulses for one cycle;
// when undefined, targets load unmodified and ALIGN_FAULT is tied low.
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int               INC_STEP  = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
  parameter int               DEPTH     = 4
) (
  input  logic      CLK,
  input  logic      RST_N,
  pc_unit_if.slave  pif
);

  localparam int               AW       = $clog2(DEPTH);
  localparam int               CW       = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(INC_STEP);

  typedef enum logic [2:0] {
    SEL_INC  = 3'b000,
    SEL_BUS  = 3'b001,
    SEL_ADDR = 3'b010,
    SEL_VEC  = 3'b011,
    SEL_RET  = 3'b100
  } pcmux_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_q [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [CW-1:0]    cnt_m1;
  logic [WIDTH-1:0] tos;
  logic             full, empty;
  logic             take, push_req, pop_req, misalign, new_err, push;
  logic [WIDTH-1:0] target;

  // Next-PC select, stack pointer update and sticky error decode
  always_comb begin
    pc_inc   = pc_q + STEP;
    cnt_m1   = cnt_q - 1'b1;
    tos      = stk_q[cnt_m1[AW-1:0]];
    full     = (cnt_q == FULL_CNT);
    empty    = (cnt_q == '0);
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    push     = 1'b0;
    new_err  = 1'b0;
    target   = pc_q;
    misalign = 1'b0;
    if (pif.LD_PC) begin
      case (pcmux_e'(pif.PCMUX))
        SEL_INC:  pc_d = pc_inc;
        SEL_BUS:  begin target = pif.BUS;    take = 1'b1; end
        SEL_ADDR: begin target = pif.ADDR;   take = 1'b1; end
        SEL_VEC:  begin target = pif.VEC_IN; take = 1'b1; push_req = 1'b1; end
        SEL_RET: begin
          // Underflow: PC holds and nothing is popped
          if (empty) new_err = 1'b1;
          else begin target = tos; take = 1'b1; pop_req = 1'b1; end
        end
        default:  new_err = 1'b1;
      endcase
    end
`ifdef PC_ALIGN_CHK_EN
    // A rejected odd target leaves PC and stack untouched and raises no STK_ERR
    misalign = take & target[0];
`endif
    if (take && !misalign) begin
      pc_d = target;
      if (push_req) begin
        // Overflow still takes the vector but drops the link
        if (full) new_err = 1'b1;
        else begin push = 1'b1; cnt_d = cnt_q + 1'b1; end
      end
      if (pop_req) cnt_d = cnt_m1;
    end
    // A new error outranks a simultaneous clear
    err_d = new_err | (err_q & ~pif.CLR_ERR);
  end

  // PC, stack count and error flag registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Return-stack storage; contents are meaningless while count is zero
  always_ff @(posedge CLK) begin
    if (push) stk_q[cnt_q[AW-1:0]] <= pc_inc;
  end

`ifdef PC_ALIGN_CHK_EN
  logic afault_q, afault_d;

  // One-cycle misalignment pulse following the rejected load
  always_comb afault_d = misalign;

  // Alignment fault register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) afault_q <= 1'b0;
    else        afault_q <= afault_d;
  end

  assign pif.ALIGN_FAULT = afault_q;
`else
  assign pif.ALIGN_FAULT = 1'b0;
`endif

  assign pif.PC_OUT    = pc_q;
  assign pif.PC_INC    = pc_inc;
  assign pif.STK_COUNT = cnt_q;
  assign pif.STK_FULL  = full;
  assign pif.STK_EMPTY = empty;
  assign pif.STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios with literal expectations followed by a
// randomized run, all compared every cycle against a queue-based model of
// the PC and return stack.
module tb_pc_unit;

  localparam logic [15:0] RV = 16'h3000;
`ifdef PC_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic CLK;
  logic RST_N;

  pc_unit_if #(.WIDTH(16), .DEPTH(4)) pif();

  pc_unit #(.WIDTH(16), .INC_STEP(2), .RESET_VEC(RV), .DEPTH(4)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .pif  (pif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  bit          m_err;
  bit          m_af;

  task automatic model_reset();
    m_pc = RV;
    m_stk.delete();
    m_err = 1'b0;
    m_af = 1'b0;
  endtask

  task automatic model_edge(input bit ld, input logic [2:0] mux,
                            input logic [15:0] b, input logic [15:0] a,
                            input logic [15:0] v, input bit clr);
    bit e;
    bit f;
    logic [15:0] t;
    logic [15:0] lnk;
    e = 1'b0;
    f = 1'b0;
    lnk = m_pc + 16'd2;
    if (ld) begin
      case (mux)
        3'd0: m_pc = lnk;
        3'd1, 3'd2: begin
          t = (mux == 3'd1) ? b : a;
          if (ALIGN && t[0]) f = 1'b1;
          else m_pc = t;
        end
        3'd3: begin
          if (ALIGN && v[0]) f = 1'b1;
          else begin
            if (m_stk.size() < 4) m_stk.push_back(lnk);
            else e = 1'b1;
            m_pc = v;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) e = 1'b1;
          else begin
            t = m_stk[$];
            if (ALIGN && t[0]) f = 1'b1;
            else m_pc = m_stk.pop_back();
          end
        end
        default: e = 1'b1;
      endcase
    end
    m_err = e | (m_err & !clr);
    m_af = f;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      logic [15:0] exp_inc;
      exp_inc = m_pc + 16'd2;
      chk("cyc PC_OUT",      pif.PC_OUT,      m_pc);
      chk("cyc PC_INC",      pif.PC_INC,      exp_inc);
      chk("cyc STK_COUNT",   pif.STK_COUNT,   m_stk.size());
      chk("cyc STK_FULL",    pif.STK_FULL,    m_stk.size() == 4);
      chk("cyc STK_EMPTY",   pif.STK_EMPTY,   m_stk.size() == 0);
      chk("cyc STK_ERR",     pif.STK_ERR,     m_err);
      chk("cyc ALIGN_FAULT", pif.ALIGN_FAULT, m_af);
    end
  end

  task automatic step(input bit ld, input logic [2:0] mux, input logic [15:0] b,
                      input logic [15:0] a, input logic [15:0] v, input bit clr);
    pif.LD_PC   = ld;
    pif.PCMUX   = mux;
    pif.BUS     = b;
    pif.ADDR    = a;
    pif.VEC_IN  = v;
    pif.CLR_ERR = clr;
    @(posedge CLK);
    model_edge(ld, mux, b, a, v, clr);
    #1;
  endtask

  task automatic reset_pulse();
    #1 RST_N = 1'b0;
    model_reset();
    #1;
    chk("async rst PC", pif.PC_OUT, RV);
    chk("async rst COUNT", pif.STK_COUNT, 0);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    pif.LD_PC = 1'b0; pif.PCMUX = 3'd0; pif.BUS = '0; pif.ADDR = '0;
    pif.VEC_IN = '0; pif.CLR_ERR = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset PC", pif.PC_OUT, 16'h3000);
    chk("reset COUNT", pif.STK_COUNT, 0);
    chk("reset EMPTY", pif.STK_EMPTY, 1);
    chk("reset FULL", pif.STK_FULL, 0);
    chk("reset ERR", pif.STK_ERR, 0);
    chk("reset AF", pif.ALIGN_FAULT, 0);
    RST_N = 1'b1;
    chk_en = 1'b1;

    // Sequential increment
    step(1, 3'd0, 0, 0, 0, 0); chk("inc1", pif.PC_OUT, 16'h3002);
    step(1, 3'd0, 0, 0, 0, 0); chk("inc2", pif.PC_OUT, 16'h3004);
    step(1, 3'd0, 0, 0, 0, 0); chk("inc3", pif.PC_OUT, 16'h3006);

    // Bus/addr loads and wrap
    step(1, 3'd1, 16'h1234, 0, 0, 0); chk("bus load", pif.PC_OUT, 16'h1234);
    step(1, 3'd2, 0, 16'hFFFE, 0, 0); chk("addr load", pif.PC_OUT, 16'hFFFE);
    step(1, 3'd0, 0, 0, 0, 0);        chk("inc wrap", pif.PC_OUT, 16'h0000);

    // Vector/return nesting
    step(1, 3'd1, 16'h3000, 0, 0, 0);
    step(1, 3'd3, 0, 0, 16'h0200, 0); chk("vec1 PC", pif.PC_OUT, 16'h0200);
    chk("vec1 COUNT", pif.STK_COUNT, 1);
    step(1, 3'd3, 0, 0, 16'h0400, 0); chk("vec2 PC", pif.PC_OUT, 16'h0400);
    chk("vec2 COUNT", pif.STK_COUNT, 2);
    step(1, 3'd4, 0, 0, 0, 0);        chk("ret1 PC", pif.PC_OUT, 16'h0202);
    step(1, 3'd4, 0, 0, 0, 0);        chk("ret2 PC", pif.PC_OUT, 16'h3002);
    chk("ret2 EMPTY", pif.STK_EMPTY, 1);

    // Overflow then underflow
    for (int k = 1; k <= 5; k++) step(1, 3'd3, 0, 0, 16'(k * 16'h0100), 0);
    chk("ovf PC", pif.PC_OUT, 16'h0500);
    chk("ovf FULL", pif.STK_FULL, 1);
    chk("ovf COUNT", pif.STK_COUNT, 4);
    chk("ovf ERR", pif.STK_ERR, 1);
    step(1, 3'd4, 0, 0, 0, 0); chk("pop1", pif.PC_OUT, 16'h0302);
    step(1, 3'd4, 0, 0, 0, 0); chk("pop2", pif.PC_OUT, 16'h0202);
    step(1, 3'd4, 0, 0, 0, 0); chk("pop3", pif.PC_OUT, 16'h0102);
    step(1, 3'd4, 0, 0, 0, 0); chk("pop4", pif.PC_OUT, 16'h3004);
    step(1, 3'd4, 0, 0, 0, 0); chk("udf PC", pif.PC_OUT, 16'h3004);
    chk("udf ERR", pif.STK_ERR, 1);
    step(0, 3'd0, 0, 0, 0, 1); chk("clr ERR", pif.STK_ERR, 0);

    // Hold, reserved code, async reset
    step(0, 3'd1, 16'hAAAA, 0, 0, 0); chk("hold PC", pif.PC_OUT, 16'h3004);
    step(1, 3'd6, 0, 0, 0, 0);        chk("rsvd PC", pif.PC_OUT, 16'h3004);
    chk("rsvd ERR", pif.STK_ERR, 1);
    step(0, 3'd0, 0, 0, 0, 1);
    step(1, 3'd3, 0, 0, 16'h0600, 0); chk("pre-rst COUNT", pif.STK_COUNT, 1);
    reset_pulse();

    // Odd bus target
    step(1, 3'd1, 16'h1235, 0, 0, 0);
    chk("odd PC", pif.PC_OUT, ALIGN ? 16'h3000 : 16'h1235);
    chk("odd AF", pif.ALIGN_FAULT, ALIGN ? 1 : 0);
    step(0, 3'd0, 0, 0, 0, 0);
    chk("odd AF drop", pif.ALIGN_FAULT, 0);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      bit ld;
      bit clr;
      logic [2:0] mux;
      logic [15:0] b, a, v;
      int r;
      ld = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      mux = (r < 14) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
      b = 16'($urandom); a = 16'($urandom); v = 16'($urandom);
      if ($urandom_range(0, 7) != 0) begin b[0] = 1'b0; a[0] = 1'b0; v[0] = 1'b0; end
      clr = ($urandom_range(0, 7) == 0);
      step(ld, mux, b, a, v, clr);
      if (i % 97 == 96) reset_pulse();
    end

    @(negedge CLK);
    #1 chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
